sine_dds_dac: RTL and testbench

SINE_DDS_DAC -- requirements
Module: sine_dds_dac

---
 rtl/sine_dds_dac.sv | 196 +++++++++++++++++++
 tb/tb_sine_dds_dac.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sine_dds_dac.sv
// Multi-channel sine DDS driving a serial DAC: per-channel phase accumulators, shared sine LUT, SPI-like shift/latch.
// Define SINE_DDS_PHASE_OFFSET_EN to take per-channel phase offsets from the phase_off port instead of even spacing.
module sine_dds_dac #(
  parameter int DATA_W   = 12,
  parameter int NCH      = 2,
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = 8,
  parameter int SCLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_inc,
`ifdef SINE_DDS_PHASE_OFFSET_EN
  input  logic [NCH*PHASE_W-1:0] phase_off,
`endif
  output logic               sclk,
  output logic               si,
  output logic               not_ld,
  output logic               busy,
  output logic               frame_done,
  output logic [DATA_W-1:0]  pdata
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW  = $clog2(2 * SCLK_DIV + 1);
  localparam int BW  = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DW-1:0]  HALF_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0]  LATCH_LAST = DW'(2 * SCLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [CHW-1:0] CH_LAST    = CHW'(NCH - 1);

  // Offset-binary sine table, rounded half away from zero, built at elaboration.
  logic [DATA_W-1:0] lut [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
    localparam real AMP  = 2.0 ** (DATA_W - 1) - 1.0;
    localparam real SR   = AMP * $sin(2.0 * 3.14159265358979323846 * k / (2.0 ** LUT_AW));
    localparam int  SV   = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
    assign lut[k] = DATA_W'(SV + 2 ** (DATA_W - 1));
  end

  logic [PHASE_W-1:0] off [NCH];
  for (genvar c = 0; c < NCH; c++) begin : g_off
`ifdef SINE_DDS_PHASE_OFFSET_EN
    assign off[c] = phase_off[c*PHASE_W +: PHASE_W];
`else
    assign off[c] = PHASE_W'((64'(c) << PHASE_W) / NCH);
`endif
  end

  logic [2:0]         state_q, state_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [DW-1:0]      div_q, div_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [DATA_W-1:0]  pdata_q, pdata_d;
  logic [PHASE_W-1:0] pinc_q, pinc_d;
  logic [PHASE_W-1:0] acc_q [NCH];
  logic [PHASE_W-1:0] acc_d [NCH];
  logic               sclk_q, sclk_d, si_q, si_d, not_ld_q, not_ld_d;
  logic               busy_q, busy_d, fd_q, fd_d;

  logic [PHASE_W-1:0] ph_sum;
  logic [LUT_AW-1:0]  lut_addr;
  logic [DATA_W-1:0]  lut_word;

  assign ph_sum   = acc_q[ch_q] + off[ch_q];
  assign lut_addr = LUT_AW'(ph_sum >> (PHASE_W - LUT_AW));
  assign lut_word = lut[lut_addr];

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    pdata_d  = pdata_q;
    pinc_d   = pinc_q;
    acc_d    = acc_q;
    sclk_d   = sclk_q;
    si_d     = si_q;
    not_ld_d = not_ld_q;
    fd_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_LOAD;
          ch_d    = '0;
          pinc_d  = phase_inc;
        end
      end
      S_LOAD: begin
        pdata_d = lut_word;
        sh_d    = lut_word;
        si_d    = lut_word[DATA_W-1];
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == HALF_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Data advances only on the falling edge so it is settled at the next rise.
          if (sclk_q) begin
            if (bit_q == BIT_LAST) begin
              state_d  = S_LATCH;
              si_d     = 1'b0;
              not_ld_d = 1'b0;
            end else begin
              bit_d = bit_q + 1'b1;
              sh_d  = sh_q << 1;
              si_d  = sh_d[DATA_W-1];
            end
          end
        end
      end
      S_LATCH: begin
        div_d = div_q + 1'b1;
        if (div_q == LATCH_LAST) begin
          div_d    = '0;
          not_ld_d = 1'b1;
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
            fd_d    = 1'b1;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        for (int c = 0; c < NCH; c++) acc_d[c] = acc_q[c] + pinc_q;
        ch_d = '0;
        // Chain straight into the next frame so there is no idle gap while enabled.
        if (en) begin
          state_d = S_LOAD;
          pinc_d  = phase_inc;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      pdata_q  <= '0;
      pinc_q   <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      sclk_q   <= 1'b0;
      si_q     <= 1'b0;
      not_ld_q <= 1'b1;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      pdata_q  <= pdata_d;
      pinc_q   <= pinc_d;
      for (int c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
      sclk_q   <= sclk_d;
      si_q     <= si_d;
      not_ld_q <= not_ld_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
    end
  end

  assign sclk       = sclk_q;
  assign si         = si_q;
  assign not_ld     = not_ld_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign pdata      = pdata_q;

endmodule

// File: tb/tb_sine_dds_dac.sv
// Directed self-checking bench for sine_dds_dac at default parameters.
// Decodes the serial stream (si on sclk rise, word on not_ld rise) and times frame_done pulses.
module tb_sine_dds_dac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] phase_inc = 16'h0000;
`ifdef SINE_DDS_PHASE_OFFSET_EN
  logic [31:0] phase_off = 32'h0;
`endif
  logic        sclk, si, not_ld, busy, frame_done;
  logic [11:0] pdata;

  sine_dds_dac dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .phase_inc (phase_inc),
`ifdef SINE_DDS_PHASE_OFFSET_EN
    .phase_off (phase_off),
`endif
    .sclk      (sclk),
    .si        (si),
    .not_ld    (not_ld),
    .busy      (busy),
    .frame_done(frame_done),
    .pdata     (pdata)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          lowcnt = 0;
  bit          busy_seen = 1'b0;
  logic [11:0] dec_sh = 12'h0;
  logic [11:0] words[$];
  logic [11:0] pds[$];
  int          fd_q[$];
  int          low_q[$];

  always @(posedge clk) cyc++;
  always @(posedge sclk) dec_sh = {dec_sh[10:0], si};
  always @(posedge not_ld) begin
    words.push_back(dec_sh);
    pds.push_back(pdata);
  end
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (busy === 1'b1) busy_seen = 1'b1;
    if (not_ld === 1'b0) lowcnt++;
    else if (lowcnt != 0) begin
      low_q.push_back(lowcnt);
      lowcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    words.delete();
    pds.delete();
    fd_q.delete();
    low_q.delete();
  endtask

  task automatic wait_fd(input int n, input string tag);
    int t = 0;
    while (fd_q.size() < n && t < 400 * n) begin
      @(negedge clk);
      t++;
    end
    chk(tag, fd_q.size(), n);
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_sclk"},   sclk,       1'b0);
    chk({pfx, "_si"},     si,         1'b0);
    chk({pfx, "_not_ld"}, not_ld,     1'b1);
    chk({pfx, "_busy"},   busy,       1'b0);
    chk({pfx, "_fdone"},  frame_done, 1'b0);
    chk({pfx, "_pdata"},  pdata,      12'd0);
  endtask

  logic [11:0] b_ch0 [5] = '{12'd2048, 12'd4095, 12'd2048, 12'd1, 12'd2048};
  logic [11:0] b_ch1 [5] = '{12'd2048, 12'd1, 12'd2048, 12'd4095, 12'd2048};

  initial begin
    int c0;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle("reset");

    // phase_inc = 0: constant words, 107-clk frames, first LOAD right after reset release
    phase_inc = 16'h0000;
    en = 1'b1;
    rst = 1'b0;
    c0 = cyc;
    clear_logs();
    wait_fd(3, "a_frames");
    if (fd_q.size() >= 3) begin
      chk("a_first_fd_latency", fd_q[0] - c0, 107);
      chk("a_period_1", fd_q[1] - fd_q[0], 107);
      chk("a_period_2", fd_q[2] - fd_q[1], 107);
    end
    chk("a_word_count", words.size(), 6);
    for (int i = 0; i < words.size(); i++) begin
      chk($sformatf("a_word_%0d", i), words[i], 12'd2048);
      chk($sformatf("a_decode_%0d", i), words[i], pds[i]);
    end
    chk("a_latch_count", low_q.size(), 6);
    for (int i = 0; i < low_q.size(); i++) chk($sformatf("a_not_ld_low_%0d", i), low_q[i], 4);

    // phase_inc = 0x4000: quarter-wave steps, wrap on frame 5
    rst = 1'b1;
    @(negedge clk);
    phase_inc = 16'h4000;
    rst = 1'b0;
    clear_logs();
    wait_fd(5, "b_frames");
    if (words.size() >= 10) begin
      for (int f = 0; f < 5; f++) begin
        chk($sformatf("b_ch0_f%0d", f), words[2*f],   b_ch0[f]);
        chk($sformatf("b_ch1_f%0d", f), words[2*f+1], b_ch1[f]);
      end
    end

    // en dropped during channel 0 shift of frame 6
    repeat (20) @(negedge clk);
    chk("c_busy_mid_shift", busy, 1'b1);
    en = 1'b0;
    n = fd_q.size();
    wait_fd(n + 1, "c_frame_finishes");
    @(negedge clk);
    #2 busy_seen = 1'b0;
    repeat (200) @(negedge clk);
    chk("c_single_fdone", fd_q.size(), n + 1);
    chk("c_busy_never", busy_seen, 1'b0);
    chk("c_not_ld_idle", not_ld, 1'b1);
    chk("c_busy_idle", busy, 1'b0);
    chk("c_sclk_idle", sclk, 1'b0);
    if (words.size() >= 12) begin
      chk("c_f6_ch0", words[10], 12'd4095);
      chk("c_f6_ch1", words[11], 12'd1);
    end

    // Reset asserted mid-shift with sclk high and si high
    phase_inc = 16'h4000;
    en = 1'b1;
    @(negedge clk);
    chk("d_load_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("d_pre_sclk", sclk, 1'b1);
    chk("d_pre_si", si, 1'b1);
    chk("d_pre_pdata", pdata, 12'd2048);
    rst = 1'b1;
    #1;
    chk_idle("d_rst");
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    wait_fd(2, "d_restart_frames");
    if (words.size() >= 4) begin
      chk("d_restart_ch0_f0", words[0], 12'd2048);
      chk("d_restart_ch0_f1", words[2], 12'd4095);
    end

`ifdef SINE_DDS_PHASE_OFFSET_EN
    // Explicit per-channel offsets: ch0 0x0000, ch1 0x4000
    rst = 1'b1;
    @(negedge clk);
    phase_inc = 16'h0000;
    phase_off = {16'h4000, 16'h0000};
    rst = 1'b0;
    clear_logs();
    wait_fd(1, "e_frames");
    if (words.size() >= 2) begin
      chk("e_ch0", words[0], 12'd2048);
      chk("e_ch1", words[1], 12'd4095);
    end
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
